pc_fetch_unit: RTL and testbench

- Fetch-stage PC sequencer for the 5-stage MIPS pipeline; sits directly downstream of the ID-stage comparator.
- Consumes the comparator flags (equal, g_or_e, greater) plus the branch/jump fields decoded in ID, and resolves taken/not-taken with one architectural delay slot.
- Drives the instruction-memory request/ready handshake and delivers {pc, instr} to the IF/ID register, honouring hazard-unit stalls.

---
 rtl/pc_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// IF-stage PC sequencer: resolves ID branches/jumps with one delay slot, runs the
// instruction-memory request/ready handshake and delivers {pc, instr} to IF/ID.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [2:0]  br_type,
    input  logic        equal,
    input  logic        g_or_e,
    input  logic        greater,
    input  logic [15:0] br_offset,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_target,
    input  logic [31:0] id_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        br_taken
);

    // Handshake: a fetch is accepted in any FETCH cycle with imem_ready=1;
    // IF/ID takes {if_pc, if_instr} in every cycle with if_valid=1.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;

    logic        br_cond;
    logic        take;
    logic [31:0] id_pc_plus4;
    logic [31:0] br_disp;
    logic [31:0] target;
    logic [31:0] next_pc;

    assign id_pc_plus4 = id_pc + 32'd4;
    assign br_disp     = {{14{br_offset[15]}}, br_offset, 2'b00};

    always_comb begin
        br_cond = 1'b0;
        target  = id_pc_plus4 + br_disp;
        case (br_type)
            3'd0:    br_cond = equal;
            3'd1:    br_cond = ~equal;
            3'd2:    br_cond = g_or_e;
            3'd3:    br_cond = greater;
            3'd4:    br_cond = ~greater;
            3'd5:    br_cond = ~g_or_e;
            3'd6: begin
                br_cond = 1'b1;
                target  = {id_pc_plus4[31:28], j_index, 2'b00};
            end
            default: begin
                br_cond = 1'b1;
                target  = jr_target;
            end
        endcase
    end

    assign br_taken = br_valid & br_cond;
    // A second branch while one is still pending is dropped; the first wins.
    assign take     = br_taken & ~pend_q;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        imem_req = 1'b0;
        if_valid = 1'b0;
        if_instr = buf_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if_instr = imem_rdata;
                if (imem_ready) begin
                    if (!stall) begin
                        if_valid = 1'b1;
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    if_valid = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The delivery in (or after) the branch cycle is the delay slot; the redirect follows it.
    always_comb begin
        if (take)        next_pc = target;
        else if (pend_q) next_pc = pend_tgt_q;
        else             next_pc = pc_q + 32'd4;

        pc_d       = if_valid ? next_pc : pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        if (if_valid) begin
            pend_d = 1'b0;
        end else if (take) begin
            pend_d     = 1'b1;
            pend_tgt_d = target;
        end
    end

    assign imem_addr = pc_q;
    assign if_pc     = pc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            buf_q      <= 32'd0;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_q      <= buf_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic checked
// against a delivery-stream model of the delay-slot redirect rules.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_valid;
    logic [2:0]  br_type;
    logic        equal;
    logic        g_or_e;
    logic        greater;
    logic [15:0] br_offset;
    logic [25:0] j_index;
    logic [31:0] jr_target;
    logic [31:0] id_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        br_taken;

    int total = 0;
    int bad   = 0;

    logic        obs_valid, obs_req, obs_ready, obs_taken;
    logic [31:0] obs_pc, obs_instr;

    logic [31:0] m_next;
    logic [31:0] m_redir;
    bit          m_redir_v;
    int          deliveries;

    pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
        .br_type(br_type), .equal(equal), .g_or_e(g_or_e), .greater(greater),
        .br_offset(br_offset), .j_index(j_index), .jr_target(jr_target),
        .id_pc(id_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_pc(if_pc), .if_instr(if_instr), .br_taken(br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic bit ref_taken(input logic [2:0] t, input logic eq, input logic ge,
                                     input logic gt);
        case (t)
            3'd0: return eq;
            3'd1: return !eq;
            3'd2: return ge;
            3'd3: return gt;
            3'd4: return !gt;
            3'd5: return !ge;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input logic [2:0] t, input logic [31:0] pc,
                                               input logic [15:0] off, input logic [25:0] idx,
                                               input logic [31:0] jr);
        logic [31:0] seq;
        int d;
        seq = pc + 32'd4;
        d   = $signed(off);
        if (t <= 3'd5) return seq + 32'(d * 4);
        if (t == 3'd6) return (seq & 32'hF000_0000) | ({6'b0, idx} << 2);
        return jr;
    endfunction

    task automatic model_reset();
        m_next    = RESET_PC;
        m_redir_v = 1'b0;
    endtask

    task automatic model_update();
        if (br_valid && !m_redir_v && ref_taken(br_type, equal, g_or_e, greater)) begin
            m_redir_v = 1'b1;
            m_redir   = ref_target(br_type, id_pc, br_offset, j_index, jr_target);
        end
        if (obs_valid) begin
            deliveries++;
            m_next    = m_redir_v ? m_redir : m_next + 32'd4;
            m_redir_v = 1'b0;
        end
    endtask

    task automatic set_mem(input bit en);
        imem_ready = en & imem_req;
        imem_rdata = imem_ready ? mem_word(imem_addr) : $urandom;
    endtask

    task automatic tick();
        @(negedge clk);
        obs_valid = if_valid;
        obs_pc    = if_pc;
        obs_instr = if_instr;
        obs_req   = imem_req;
        obs_ready = imem_ready;
        obs_taken = br_taken;
        @(posedge clk);
        #1;
    endtask

    task automatic set_branch(input logic [2:0] t, input logic eq, input logic ge,
                              input logic gt, input logic [15:0] off,
                              input logic [31:0] pc, input logic [31:0] jr);
        br_valid  = 1'b1;
        br_type   = t;
        equal     = eq;
        g_or_e    = ge;
        greater   = gt;
        br_offset = off;
        id_pc     = pc;
        jr_target = jr;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset      = 1'b0;
        stall      = 1'b0;
        br_valid   = 1'b0;
        imem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    // Brings the unit out of reset and through the IDLE cycle and first delivery (0x3000).
    task automatic warm_up();
        do_reset();
        set_mem(1'b1);
        tick();
        model_update();
        set_mem(1'b1);
        tick();
        model_update();
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
        total++; if (if_pc !== RESET_PC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", if_pc, RESET_PC); end
        total++; if (if_instr !== 32'd0) begin bad++; $display("FAIL reset_instr got=%h exp=0", if_instr); end
        total++; if (br_taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%b exp=0", br_taken); end
        br_valid = 1'b1;
        br_type  = 3'd6;
        #1;
        total++; if (br_taken !== 1'b1) begin bad++; $display("FAIL reset_taken_j got=%b exp=1", br_taken); end
        br_valid = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        do_reset();
        set_mem(1'b1);
        tick();
        total++; if (obs_req !== 1'b0) begin bad++; $display("FAIL seq_idle_req got=%b exp=0", obs_req); end
        total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL seq_idle_valid got=%b exp=0", obs_valid); end
        model_update();
        for (int i = 0; i < 3; i++) begin
            exp_pc = RESET_PC + 32'(4 * i);
            set_mem(1'b1);
            tick();
            total++; if (obs_req !== 1'b1) begin bad++; $display("FAIL seq_req[%0d] got=%b exp=1", i, obs_req); end
            total++; if (obs_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, obs_valid); end
            total++; if (obs_pc !== exp_pc) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, obs_pc, exp_pc); end
            total++; if (obs_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, obs_instr, mem_word(exp_pc)); end
            model_update();
        end
    endtask

    task automatic test_beq();
        logic [31:0] exp_pc;
        for (int pass = 0; pass < 2; pass++) begin
            warm_up();
            set_branch(3'd0, pass == 0, 1'b0, 1'b0, 16'h0003, 32'h0000_3000, 32'd0);
            set_mem(1'b1);
            tick();
            total++; if (obs_taken !== (pass == 0)) begin bad++; $display("FAIL beq_taken[%0d] got=%b exp=%b", pass, obs_taken, pass == 0); end
            total++; if (obs_valid !== 1'b1 || obs_pc !== 32'h0000_3004) begin bad++; $display("FAIL beq_slot[%0d] got=%b/%h exp=1/00003004", pass, obs_valid, obs_pc); end
            model_update();
            br_valid = 1'b0;
            set_mem(1'b1);
            tick();
            exp_pc = (pass == 0) ? 32'h0000_3010 : 32'h0000_3008;
            total++; if (obs_valid !== 1'b1 || obs_pc !== exp_pc) begin bad++; $display("FAIL beq_next[%0d] got=%b/%h exp=1/%h", pass, obs_valid, obs_pc, exp_pc); end
            model_update();
        end
    endtask

    task automatic test_bltz_blez();
        warm_up();
        set_branch(3'd5, 1'b0, 1'b0, 1'b0, 16'hFFFF, 32'h0000_3010, 32'd0);
        set_mem(1'b1);
        tick();
        total++; if (obs_taken !== 1'b1) begin bad++; $display("FAIL bltz_taken got=%b exp=1", obs_taken); end
        model_update();
        set_branch(3'd4, 1'b0, 1'b1, 1'b1, 16'h0040, 32'h0000_3010, 32'd0);
        set_mem(1'b1);
        tick();
        total++; if (obs_pc !== 32'h0000_3010) begin bad++; $display("FAIL bltz_target got=%h exp=00003010", obs_pc); end
        total++; if (obs_taken !== 1'b0) begin bad++; $display("FAIL blez_taken got=%b exp=0", obs_taken); end
        model_update();
        br_valid = 1'b0;
        set_mem(1'b1);
        tick();
        total++; if (obs_pc !== 32'h0000_3014) begin bad++; $display("FAIL blez_next got=%h exp=00003014", obs_pc); end
        model_update();
    endtask

    task automatic test_stall_hold();
        int accepts;
        warm_up();
        accepts = 0;
        stall   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_mem(1'b1);
            tick();
            if (obs_req && obs_ready) accepts++;
            total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL hold_valid[%0d] got=%b exp=0", i, obs_valid); end
            model_update();
        end
        stall = 1'b0;
        set_mem(1'b1);
        tick();
        if (obs_req && obs_ready) accepts++;
        total++; if (obs_valid !== 1'b1 || obs_pc !== 32'h0000_3004) begin bad++; $display("FAIL hold_release got=%b/%h exp=1/00003004", obs_valid, obs_pc); end
        total++; if (obs_instr !== mem_word(32'h0000_3004)) begin bad++; $display("FAIL hold_instr got=%h exp=%h", obs_instr, mem_word(32'h0000_3004)); end
        total++; if (accepts !== 1) begin bad++; $display("FAIL hold_accepts got=%0d exp=1", accepts); end
        model_update();
        set_mem(1'b1);
        tick();
        total++; if (obs_valid !== 1'b1 || obs_pc !== 32'h0000_3008) begin bad++; $display("FAIL hold_after got=%b/%h exp=1/00003008", obs_valid, obs_pc); end
        model_update();
    endtask

    task automatic test_jr_pend();
        logic [31:0] exp_seq [3];
        exp_seq = '{32'h0000_3004, 32'h0000_4000, 32'h0000_4004};
        warm_up();
        set_branch(3'd7, 1'b0, 1'b0, 1'b0, 16'd0, 32'h0000_3000, 32'h0000_4000);
        set_mem(1'b0);
        tick();
        total++; if (obs_taken !== 1'b1 || obs_valid !== 1'b0) begin bad++; $display("FAIL jr_issue got=%b/%b exp=1/0", obs_taken, obs_valid); end
        model_update();
        br_valid = 1'b0;
        set_mem(1'b0);
        tick();
        total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL jr_wait got=%b exp=0", obs_valid); end
        model_update();
        for (int i = 0; i < 3; i++) begin
            set_mem(1'b1);
            tick();
            total++; if (obs_valid !== 1'b1 || obs_pc !== exp_seq[i]) begin bad++; $display("FAIL jr_seq[%0d] got=%b/%h exp=1/%h", i, obs_valid, obs_pc, exp_seq[i]); end
            model_update();
        end
    endtask

    task automatic test_reset_midfetch();
        warm_up();
        set_branch(3'd7, 1'b0, 1'b0, 1'b0, 16'd0, 32'h0000_3000, 32'h0000_5000);
        set_mem(1'b0);
        tick();
        br_valid = 1'b0;
        set_mem(1'b0);
        #2;
        reset = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rstmid_req got=%b exp=0", imem_req); end
        total++; if (if_pc !== RESET_PC) begin bad++; $display("FAIL rstmid_pc got=%h exp=%h", if_pc, RESET_PC); end
        imem_ready = 1'b1;
        imem_rdata = $urandom;
        @(posedge clk);
        #1;
        total++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL rstmid_late got=%b/%b exp=0/0", if_valid, imem_req); end
        reset = 1'b1;
        model_reset();
        set_mem(1'b1);
        tick();
        total++; if (obs_req !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b exp=0", obs_req); end
        model_update();
        for (int i = 0; i < 2; i++) begin
            set_mem(1'b1);
            tick();
            total++; if (obs_valid !== 1'b1 || obs_pc !== RESET_PC + 32'(4 * i)) begin bad++; $display("FAIL rstmid_seq[%0d] got=%b/%h exp=1/%h", i, obs_valid, obs_pc, RESET_PC + 32'(4 * i)); end
            model_update();
        end
    endtask

    task automatic test_random();
        bit ready_en;
        int start_del;
        do_reset();
        start_del = deliveries;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            stall    = ($urandom_range(0, 3) == 0);
            ready_en = ($urandom_range(0, 2) != 0);
            br_valid = 1'b0;
            if (!stall && !m_redir_v && $urandom_range(0, 2) == 0) begin
                set_branch(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
                           16'($urandom), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                           {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
                j_index = 26'($urandom);
            end
            set_mem(ready_en);
            tick();
            if (stall) begin
                total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL rnd_stall_valid[%0d] got=%b exp=0", cyc, obs_valid); end
            end
            if (br_valid) begin
                total++; if (obs_taken !== ref_taken(br_type, equal, g_or_e, greater)) begin bad++; $display("FAIL rnd_taken[%0d] type=%0d got=%b exp=%b", cyc, br_type, obs_taken, ref_taken(br_type, equal, g_or_e, greater)); end
            end
            if (obs_valid) begin
                total++; if (obs_pc !== m_next) begin bad++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", cyc, obs_pc, m_next); end
                total++; if (obs_instr !== mem_word(obs_pc)) begin bad++; $display("FAIL rnd_instr[%0d] got=%h exp=%h", cyc, obs_instr, mem_word(obs_pc)); end
            end
            model_update();
        end
        br_valid = 1'b0;
        stall    = 1'b0;
        total++; if (deliveries - start_del < 500) begin bad++; $display("FAIL rnd_progress got=%0d exp>=500", deliveries - start_del); end
    endtask

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        br_valid   = 1'b0;
        br_type    = 3'd0;
        equal      = 1'b0;
        g_or_e     = 1'b0;
        greater    = 1'b0;
        br_offset  = 16'd0;
        j_index    = 26'd0;
        jr_target  = 32'd0;
        id_pc      = 32'd0;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        deliveries = 0;
        model_reset();
        test_reset();
        test_sequential();
        test_beq();
        test_bltz_blez();
        test_stall_hold();
        test_jr_pend();
        test_reset_midfetch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
